// File: rtl/alu_ctrl_fsm_pkg.sv
// Shared types and encodings for the multicycle ALU control unit.
// Instruction layout is [7:6] opcode, [5:4] rd, [3:2] rs1/rs, [1:0] rs2/sel.
package alu_ctrl_fsm_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_UNARY = 2'b01;
  localparam logic [1:0] OP_NOP   = 2'b10;
  localparam logic [1:0] OP_HALT  = 2'b11;

  localparam logic [1:0] SEL_PASS = 2'b00;
  localparam logic [1:0] SEL_INC  = 2'b01;
  localparam logic [1:0] SEL_SUB2 = 2'b10;
  localparam logic [1:0] SEL_DEC  = 2'b11;

  // For UNARY the rs2 field carries the ALU unary selector.
  typedef struct packed {
    logic [1:0] op;
    logic [1:0] rd;
    logic [1:0] rs1;
    logic [1:0] rs2;
  } instr_t;

endpackage

// File: rtl/alu_ctrl_fetch.sv
// Instruction-fetch handshake: registered request, timeout counter and
// instruction latch. The parent FSM owns the state; this block reports events.
module alu_ctrl_fetch
  import alu_ctrl_fsm_pkg::*;
#(
  parameter int unsigned FETCH_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_fetch_i,
  input  logic       fetch_next_i,
  input  logic       imem_valid_i,
  input  logic [7:0] imem_data_i,
  output logic       imem_req_o,
  output logic       done_o,
  output logic       timeout_o,
  output logic [7:0] instr_o
);

  localparam logic [7:0] CNT_LAST = 8'(FETCH_TIMEOUT - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       req_q;
  instr_t     instr_q, instr_d;

  // VALID wins over timeout when both land in the final FETCH cycle.
  assign done_o    = in_fetch_i & imem_valid_i;
  assign timeout_o = in_fetch_i & ~imem_valid_i & (cnt_q == CNT_LAST);

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    cnt_d   = 8'd0;
    instr_d = instr_q;
    if (in_fetch_i && fetch_next_i) cnt_d = cnt_q + 8'd1;
    if (done_o)                     instr_d = instr_t'(imem_data_i);
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= 8'd0;
      req_q   <= 1'b0;
      instr_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      req_q   <= fetch_next_i;
      instr_q <= instr_d;
    end
  end

  assign imem_req_o = req_q;
  assign instr_o    = instr_q;

endmodule

// File: rtl/alu_ctrl_fsm.sv
// Multicycle control unit: fetches 8-bit instructions and drives the ALU
// controls, register-file addresses/write enable and the PC. All outputs registered.
module alu_ctrl_fsm
  import alu_ctrl_fsm_pkg::*;
#(
  parameter logic [7:0]  PC_RESET      = 8'h00,
  parameter int unsigned FETCH_TIMEOUT = 15
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       START,
  output logic       IMEM_REQ,
  output logic [7:0] IMEM_ADDR,
  input  logic       IMEM_VALID,
  input  logic [7:0] IMEM_DATA,
  output logic       ALUSRC,
  output logic       ALUOP,
  output logic [1:0] ALU_SEL,
  output logic [1:0] RF_RA,
  output logic [1:0] RF_RB,
  output logic       RF_WE,
  output logic [1:0] RF_WA,
  output logic       BUSY,
  output logic       HALTED,
  output logic       ERR,
  output logic [7:0] RETIRED
);

  state_t     state_q, state_d;
  logic [7:0] pc_q, pc_d, retired_q, retired_d;
  logic       err_q, err_d, busy_q, busy_d, halted_q, halted_d;
  logic       alusrc_q, alusrc_d, aluop_q, aluop_d, rf_we_q, rf_we_d;
  logic [1:0] alu_sel_q, alu_sel_d, rf_ra_q, rf_ra_d, rf_rb_q, rf_rb_d, rf_wa_q, rf_wa_d;

  logic       fetch_done, fetch_timeout;
  logic [7:0] fetch_instr;
  instr_t     instr, imem_word;

  assign instr     = instr_t'(fetch_instr);
  assign imem_word = instr_t'(IMEM_DATA);

  alu_ctrl_fetch #(
    .FETCH_TIMEOUT(FETCH_TIMEOUT)
  ) u_fetch (
    .clk          (CLK),
    .rst_n        (RST_N),
    .in_fetch_i   (state_q == S_FETCH),
    .fetch_next_i (state_d == S_FETCH),
    .imem_valid_i (IMEM_VALID),
    .imem_data_i  (IMEM_DATA),
    .imem_req_o   (IMEM_REQ),
    .done_o       (fetch_done),
    .timeout_o    (fetch_timeout),
    .instr_o      (fetch_instr)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    err_d     = err_q;
    rf_ra_d   = rf_ra_q;
    rf_rb_d   = rf_rb_q;
    rf_wa_d   = rf_wa_q;
    alusrc_d  = 1'b0;
    aluop_d   = 1'b0;
    alu_sel_d = SEL_PASS;
    rf_we_d   = 1'b0;

    case (state_q)
      S_IDLE: if (START) state_d = S_FETCH;
      S_FETCH: begin
        // Read addresses are registered on the handshake edge so they are valid in DECODE.
        if (fetch_done) begin
          state_d = S_DECODE;
          if (imem_word.op == OP_ADD) begin
            rf_ra_d = imem_word.rs1;
            rf_rb_d = imem_word.rs2;
          end else if (imem_word.op == OP_UNARY) begin
            rf_ra_d = imem_word.rs1;
            rf_rb_d = 2'b00;
          end
        end else if (fetch_timeout) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end
      end
      S_DECODE: begin
        case (instr.op)
          OP_ADD: begin
            state_d   = S_EXEC;
            aluop_d   = 1'b1;
            alusrc_d  = 1'b0;
            alu_sel_d = SEL_PASS;
          end
          OP_UNARY: begin
            state_d   = S_EXEC;
            aluop_d   = 1'b1;
            alusrc_d  = 1'b1;
            alu_sel_d = instr.rs2;
          end
          OP_NOP: begin
            state_d   = S_FETCH;
            pc_d      = pc_q + 8'd1;
            retired_d = retired_q + 8'd1;
          end
          default: state_d = S_HALT;
        endcase
      end
      S_EXEC: begin
        // ALU controls held through WB so the result is stable at the write edge.
        state_d   = S_WB;
        alusrc_d  = alusrc_q;
        aluop_d   = aluop_q;
        alu_sel_d = alu_sel_q;
        rf_we_d   = 1'b1;
        rf_wa_d   = instr.rd;
      end
      S_WB: begin
        state_d   = S_FETCH;
        pc_d      = pc_q + 8'd1;
        retired_d = retired_q + 8'd1;
      end
      S_HALT: begin
        if (START) begin
          state_d   = S_FETCH;
          pc_d      = PC_RESET;
          retired_d = 8'd0;
          err_d     = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d   = (state_d == S_FETCH) || (state_d == S_DECODE) ||
               (state_d == S_EXEC)  || (state_d == S_WB);
    halted_d = (state_d == S_HALT);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= S_IDLE;
      pc_q      <= PC_RESET;
      retired_q <= 8'd0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
      alusrc_q  <= 1'b0;
      aluop_q   <= 1'b0;
      alu_sel_q <= 2'b00;
      rf_ra_q   <= 2'b00;
      rf_rb_q   <= 2'b00;
      rf_we_q   <= 1'b0;
      rf_wa_q   <= 2'b00;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      halted_q  <= halted_d;
      alusrc_q  <= alusrc_d;
      aluop_q   <= aluop_d;
      alu_sel_q <= alu_sel_d;
      rf_ra_q   <= rf_ra_d;
      rf_rb_q   <= rf_rb_d;
      rf_we_q   <= rf_we_d;
      rf_wa_q   <= rf_wa_d;
    end
  end

  assign IMEM_ADDR = pc_q;
  assign ALUSRC    = alusrc_q;
  assign ALUOP     = aluop_q;
  assign ALU_SEL   = alu_sel_q;
  assign RF_RA     = rf_ra_q;
  assign RF_RB     = rf_rb_q;
  assign RF_WE     = rf_we_q;
  assign RF_WA     = rf_wa_q;
  assign BUSY      = busy_q;
  assign HALTED    = halted_q;
  assign ERR       = err_q;
  assign RETIRED   = retired_q;

endmodule
